univ_shift_reg_seq: RTL and testbench
=====================================

Name: univ_shift_reg_seq

Overview:
Parametrised N-bit universal shift register with multi-position sequenced operations. Adds rotate, arithmetic shift, a shift-amount count and a start/busy/done handshake, so one command shifts by several positions at one position per clock. It serves as the general shift/rotate datapath element for serial links and bit-manipulation blocks in the design.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, 4, width of the shift-amount input
RST_VAL, 0, value loaded into o_q on reset (WIDTH bits)

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst  input  1  synchronous active-low reset
i_start  input  1  command strobe; accepted only in IDLE
i_mode  input  3  0 hold, 1 shift up, 2 shift down, 3 parallel load, 4 rotate up, 5 rotate down, 6 arithmetic shift down, 7 reserved (treated as hold)
i_amt  input  AMT_W  number of single-position steps
i_sin_up  input  1  serial in at bit 0 for shift up
i_sin_dn  input  1  serial in at bit WIDTH-1 for shift down
i_p  input  WIDTH  parallel load data
o_q  output  WIDTH  register contents
o_sout_up  output  1  last bit shifted or rotated out of bit WIDTH-1
o_sout_dn  output  1  last bit shifted or rotated out of bit 0
o_busy  output  1  high while a multi-step command is in progress
o_done  output  1  one-cycle pulse marking command completion

Behaviour:
- Reset (i_rst=0 at an edge): o_q=RST_VAL, o_sout_up=0, o_sout_dn=0, o_busy=0, o_done=0, state IDLE, step counter 0. Reset overrides i_start and any command in progress.
- States: IDLE and RUN. Mode is latched at acceptance. Remaining count is held internally.
- Single step definitions, with q = current o_q:
  - Shift up: q <= {q[W-2:0], i_sin_up}; o_sout_up <= q[W-1].
  - Shift down: q <= {i_sin_dn, q[W-1:1]}; o_sout_dn <= q[0].
  - Rotate up: q <= {q[W-2:0], q[W-1]}; o_sout_up <= q[W-1].
  - Rotate down: q <= {q[0], q[W-1:1]}; o_sout_dn <= q[0].
  - Arithmetic shift down: q <= {q[W-1], q[W-1:1]}; o_sout_dn <= q[0].
- Serial inputs are sampled live at every step edge, not latched at start.
- IDLE with i_start=1:
  - Mode 3: o_q <= i_p. o_done=1 next cycle. Stay IDLE. i_amt is ignored.
  - Mode 0 or 7, or i_amt=0 with any mode: no change to o_q or sout. o_done=1 next cycle. Stay IDLE.
  - Otherwise the first step executes on the accept edge and the remaining count is set to i_amt-1.
    - If i_amt=1: o_done=1 next cycle, stay IDLE.
    - Else: o_busy<=1, go to RUN.
- RUN: one step per edge and the count decrements.
  - On the edge that executes the final step: o_busy<=0, o_done<=1, go to IDLE.
  - A command of amount N therefore takes N edges. o_busy is high for N-1 cycles. o_done is high in the cycle after the last step.
- i_start in RUN is ignored, with no queuing.
- i_start while o_done=1 is accepted, since the block is back in IDLE; back-to-back commands are legal.
- o_done is low in every cycle except completion cycles.
- i_amt may exceed WIDTH:
  - Shifts fully flush the register with serial-in (or sign) values.
  - Rotates wrap modulo WIDTH.
- o_sout_up and o_sout_dn hold their value between commands and are unchanged by load, hold, and opposite-direction steps.
- Inputs other than i_start are don't-care outside the accept cycle, except the serial inputs.

Test Plan:
- Reset: i_rst=0 for 2 edges with i_start=1, mode 3, i_p=8'hA5 -> o_q=8'h00, o_busy=0, o_done=0, sout=0.
- Load: mode 3, i_p=8'hA5, i_start pulse -> next cycle o_q=8'hA5, o_done=1 for exactly 1 cycle, o_busy never high.
- Shift up amt=3, i_sin_up=1, start from 8'hA5 -> o_q goes 8'h4B, 8'h97, 8'h2F. o_busy high 2 cycles, o_done with o_q=8'h2F, o_sout_up=1.
- Arithmetic shift down amt=2 from 8'h96 -> 8'hCB then 8'hE5, o_sout_dn=1. Then back-to-back rotate up amt=1 started in the o_done cycle -> 8'hCB, o_sout_up=1.
- Rotate down amt=9 from 8'h81 -> final o_q=8'hC0. o_busy high 8 cycles, o_done on cycle 9. An i_start with mode 3 issued mid-run is ignored.
- Reset mid-run: rotate up amt=5 from 8'h01, i_rst=0 after 2 steps -> o_q=8'h00, o_busy=0, no o_done pulse. A new shift up amt=1 afterwards works normally.

Source files
------------

// File: rtl/univ_shift_reg_seq.sv
// Universal shift/rotate register that runs one multi-step command at a time.
// Each accepted command performs i_amt single-position steps, one per clock.
module univ_shift_reg_seq #(
  parameter int unsigned          WIDTH   = 8,
  parameter int unsigned          AMT_W   = 4,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  input  logic [AMT_W-1:0] i_amt,
  input  logic             i_sin_up,
  input  logic             i_sin_dn,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout_up,
  output logic             o_sout_dn,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SHU  = 3'd1;
  localparam logic [2:0] M_SHD  = 3'd2;
  localparam logic [2:0] M_LOAD = 3'd3;
  localparam logic [2:0] M_ROU  = 3'd4;
  localparam logic [2:0] M_ROD  = 3'd5;
  localparam logic [2:0] M_ASD  = 3'd6;

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_up_q, sout_up_d;
  logic             sout_dn_q, sout_dn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_ok;
  logic             step_up;
  logic             step_dn;

  // In RUN the latched mode drives the step; in IDLE the incoming one does.
  always_comb begin
    step_mode = (state_q == S_RUN) ? mode_q : i_mode;
    step_q    = q_q;
    step_ok   = 1'b1;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    unique case (1'b1)
      (step_mode == M_SHU): begin
        step_q  = {q_q[WIDTH-2:0], i_sin_up};
        step_up = 1'b1;
      end
      (step_mode == M_SHD): begin
        step_q  = {i_sin_dn, q_q[WIDTH-1:1]};
        step_dn = 1'b1;
      end
      (step_mode == M_ROU): begin
        step_q  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_up = 1'b1;
      end
      (step_mode == M_ROD): begin
        step_q  = {q_q[0], q_q[WIDTH-1:1]};
        step_dn = 1'b1;
      end
      (step_mode == M_ASD): begin
        step_q  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_dn = 1'b1;
      end
      default: step_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    sout_up_d = sout_up_q;
    sout_dn_d = sout_dn_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_mode == M_LOAD) begin
            q_d    = i_p;
            done_d = 1'b1;
          end else if (!step_ok || i_amt == '0) begin
            done_d = 1'b1;
          end else begin
            q_d    = step_q;
            mode_d = i_mode;
            cnt_d  = i_amt - AMT_W'(1);
            if (step_up) sout_up_d = q_q[WIDTH-1];
            if (step_dn) sout_dn_d = q_q[0];
            if (i_amt == AMT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
          end
        end
      end
      S_RUN: begin
        q_d   = step_q;
        cnt_d = cnt_q - AMT_W'(1);
        if (step_up) sout_up_d = q_q[WIDTH-1];
        if (step_dn) sout_dn_d = q_q[0];
        if (cnt_q == AMT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      mode_q    <= M_HOLD;
      cnt_q     <= '0;
      q_q       <= RST_VAL;
      sout_up_q <= 1'b0;
      sout_dn_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      sout_up_q <= sout_up_d;
      sout_dn_q <= sout_dn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_q       = q_q;
  assign o_sout_up = sout_up_q;
  assign o_sout_dn = sout_dn_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Scoreboard bench for univ_shift_reg_seq: per-cycle expected outputs
// are queued with the stimulus and popped after each clock edge.
module tb_univ_shift_reg_seq;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [2:0] i_mode;
  logic [3:0] i_amt;
  logic       i_sin_up;
  logic       i_sin_dn;
  logic [7:0] i_p;
  logic [7:0] o_q;
  logic       o_sout_up;
  logic       o_sout_dn;
  logic       o_busy;
  logic       o_done;

  univ_shift_reg_seq #(
    .WIDTH(8), .AMT_W(4), .RST_VAL(8'h00)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_mode(i_mode), .i_amt(i_amt),
    .i_sin_up(i_sin_up), .i_sin_dn(i_sin_dn), .i_p(i_p),
    .o_q(o_q), .o_sout_up(o_sout_up), .o_sout_dn(o_sout_dn),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] p;
    logic       su;
    logic       sd;
  } stim_t;

  // {q, busy, done, sout_up, sout_dn}
  typedef logic [11:0] exp_t;

  exp_t sb[$];
  exp_t got, want;
  int   n_checks = 0;
  int   n_err = 0;

  function automatic stim_t mk(logic rst, logic start, logic [2:0] mode,
                               logic [3:0] amt, logic [7:0] p,
                               logic su, logic sd);
    stim_t s;
    s = '{rst:rst, start:start, mode:mode, amt:amt, p:p, su:su, sd:sd};
    return s;
  endfunction

  function automatic stim_t idle(logic su, logic sd);
    return mk(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, su, sd);
  endfunction

  function automatic exp_t e(logic [7:0] q, logic b, logic d,
                             logic u, logic n);
    return {q, b, d, u, n};
  endfunction

  function automatic exp_t obs();
    return {o_q, o_busy, o_done, o_sout_up, o_sout_dn};
  endfunction

  task automatic apply(stim_t s);
    i_rst    = s.rst;
    i_start  = s.start;
    i_mode   = s.mode;
    i_amt    = s.amt;
    i_p      = s.p;
    i_sin_up = s.su;
    i_sin_dn = s.sd;
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(mk(0, 1, 3, 0, 8'hA5, 0, 0)); ex.push_back(e(8'h00, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 3, 0, 8'hA5, 0, 0)); ex.push_back(e(8'h00, 0, 0, 0, 0));
    st.push_back(idle(0, 0));                  ex.push_back(e(8'h00, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge i_clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_load();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(mk(1, 1, 3, 0, 8'hA5, 0, 0)); ex.push_back(e(8'hA5, 0, 1, 0, 0));
    st.push_back(idle(0, 0));                  ex.push_back(e(8'hA5, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge i_clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL load[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_shift_up();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(mk(1, 1, 1, 3, 8'h00, 1, 0)); ex.push_back(e(8'h4B, 1, 0, 1, 0));
    st.push_back(idle(1, 0));                  ex.push_back(e(8'h97, 1, 0, 0, 0));
    st.push_back(idle(1, 0));                  ex.push_back(e(8'h2F, 0, 1, 1, 0));
    st.push_back(idle(0, 0));                  ex.push_back(e(8'h2F, 0, 0, 1, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge i_clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL shift_up[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(mk(1, 1, 3, 0, 8'h96, 0, 0)); ex.push_back(e(8'h96, 0, 1, 1, 0));
    st.push_back(mk(1, 1, 6, 2, 8'h00, 0, 0)); ex.push_back(e(8'hCB, 1, 0, 1, 0));
    st.push_back(idle(0, 0));                  ex.push_back(e(8'hE5, 0, 1, 1, 1));
    st.push_back(mk(1, 1, 4, 1, 8'h00, 0, 0)); ex.push_back(e(8'hCB, 0, 1, 1, 1));
    st.push_back(idle(0, 0));                  ex.push_back(e(8'hCB, 0, 0, 1, 1));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge i_clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  // Rotate down by 9 wraps to a single-position rotation; a load strobe
  // in the middle of the run must not disturb it.
  task automatic test_rotate_wrap();
    stim_t      st[$];
    exp_t       ex[$];
    logic [7:0] qs [9];
    logic       sds[9];
    qs  = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81, 8'hC0};
    sds = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    st.push_back(mk(1, 1, 3, 0, 8'h81, 0, 0)); ex.push_back(e(8'h81, 0, 1, 1, 1));
    for (int k = 0; k < 9; k++) begin
      if (k == 0)      st.push_back(mk(1, 1, 5, 9, 8'h00, 0, 0));
      else if (k == 4) st.push_back(mk(1, 1, 3, 1, 8'hFF, 0, 0));
      else             st.push_back(idle(0, 0));
      ex.push_back(e(qs[k], k < 8, k == 8, 1'b1, sds[k]));
    end
    st.push_back(idle(0, 0)); ex.push_back(e(8'hC0, 0, 0, 1, 1));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge i_clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL rotate_wrap[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(mk(1, 1, 3, 0, 8'h01, 0, 0)); ex.push_back(e(8'h01, 0, 1, 1, 1));
    st.push_back(mk(1, 1, 4, 5, 8'h00, 0, 0)); ex.push_back(e(8'h02, 1, 0, 0, 1));
    st.push_back(idle(0, 0));                  ex.push_back(e(8'h04, 1, 0, 0, 1));
    st.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0)); ex.push_back(e(8'h00, 0, 0, 0, 0));
    st.push_back(idle(0, 0));                  ex.push_back(e(8'h00, 0, 0, 0, 0));
    st.push_back(idle(0, 0));                  ex.push_back(e(8'h00, 0, 0, 0, 0));
    st.push_back(mk(1, 1, 1, 1, 8'h00, 1, 0)); ex.push_back(e(8'h01, 0, 1, 0, 0));
    st.push_back(idle(0, 0));                  ex.push_back(e(8'h01, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge i_clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_mid_run[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  // Hold, reserved mode and zero amount complete at once without change;
  // a long shift down then flushes the register with the serial input.
  task automatic test_hold_and_flush();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(mk(1, 1, 0, 3, 8'hFF, 1, 1)); ex.push_back(e(8'h01, 0, 1, 0, 0));
    st.push_back(mk(1, 1, 7, 2, 8'hFF, 1, 1)); ex.push_back(e(8'h01, 0, 1, 0, 0));
    st.push_back(mk(1, 1, 1, 0, 8'hFF, 1, 1)); ex.push_back(e(8'h01, 0, 1, 0, 0));
    st.push_back(idle(1, 1));                  ex.push_back(e(8'h01, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      if (k == 0) st.push_back(mk(1, 1, 2, 10, 8'h00, 1, 0));
      else        st.push_back(idle(1, 0));
      ex.push_back(e(8'h00, k < 9, k == 9, 1'b0, k == 0));
    end
    st.push_back(idle(0, 0)); ex.push_back(e(8'h00, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge i_clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL hold_flush[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    apply(mk(0, 0, 0, 0, 8'h00, 0, 0));
    #1;
    test_reset();
    test_load();
    test_shift_up();
    test_back_to_back();
    test_rotate_wrap();
    test_reset_mid_run();
    test_hold_and_flush();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
